// File: rtl/answer_arbiter.sv
// Two-player answer arbiter for the factorization duel: grants the judgement slot
// to the first correct answer, locks out wrong answerers and keeps both players' HP.
module answer_arbiter #(
  parameter int ANS_W      = 8,
  parameter int HP_INIT    = 3,
  parameter int WRONG_HOLD = 2
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [3:0]       STATE_IN,
  input  logic             NEW_GAME,
  input  logic [ANS_W-1:0] KEY_A,
  input  logic [ANS_W-1:0] KEY_B,
  input  logic             P1_VALID,
  input  logic             P2_VALID,
  input  logic [ANS_W-1:0] P1_ANS,
  input  logic [ANS_W-1:0] P2_ANS,
  output logic [1:0]       JUDG_OUT,
  output logic             WRONG_OUT,
  output logic [1:0]       HP_OUT,
  output logic [2:0]       DBG_STATE,
  output logic [2:0]       DBG_HP1,
  output logic [2:0]       DBG_HP2
);

  // Handshake: P*_VALID is a one-cycle pulse with no back-pressure; the answer is
  // taken on that edge only if the arbiter is OPEN/WPULSE and the player is unlocked.

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_OPEN    = 3'd1,
    S_CHECK   = 3'd2,
    S_WPULSE  = 3'd3,
    S_DECIDED = 3'd4,
    S_OVER    = 3'd5
  } state_t;

  localparam logic [3:0] ST_READY    = 4'b0010;
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;
  localparam logic [2:0] HP_RST      = 3'(HP_INIT);
  localparam int         CNT_W       = (WRONG_HOLD > 1) ? $clog2(WRONG_HOLD) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WRONG_HOLD - 1);

  state_t           state_q;
  logic [ANS_W-1:0] p1_ans_q, p2_ans_q;
  logic             p1_vld_q, p2_vld_q;
  logic             p1_lock_q, p2_lock_q;
  logic [2:0]       hp1_q, hp2_q;
  logic [CNT_W-1:0] cnt_q;

  logic       p1_ok, p2_ok, p1_bad, p2_bad;
  logic       p1_take, p2_take;
  logic       lock1_d, lock2_d;
  logic [2:0] hp1_d, hp2_d;

  always_comb begin
    p1_ok   = p1_vld_q && ((p1_ans_q == KEY_A) || (p1_ans_q == KEY_B));
    p2_ok   = p2_vld_q && ((p2_ans_q == KEY_A) || (p2_ans_q == KEY_B));
    p1_bad  = p1_vld_q && !p1_ok;
    p2_bad  = p2_vld_q && !p2_ok;
    p1_take = P1_VALID && !p1_lock_q;
    p2_take = P2_VALID && !p2_lock_q;
    lock1_d = p1_lock_q | p1_bad;
    lock2_d = p2_lock_q | p2_bad;
    hp1_d   = (hp1_q == 3'd0) ? 3'd0 : hp1_q - 3'd1;
    hp2_d   = (hp2_q == 3'd0) ? 3'd0 : hp2_q - 3'd1;
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q   <= S_IDLE;
      p1_ans_q  <= '0;
      p2_ans_q  <= '0;
      p1_vld_q  <= 1'b0;
      p2_vld_q  <= 1'b0;
      p1_lock_q <= 1'b0;
      p2_lock_q <= 1'b0;
      hp1_q     <= HP_RST;
      hp2_q     <= HP_RST;
      cnt_q     <= '0;
      JUDG_OUT  <= 2'b00;
      WRONG_OUT <= 1'b0;
      HP_OUT    <= 2'b00;
    end else if (NEW_GAME) begin
      state_q   <= S_IDLE;
      p1_ans_q  <= '0;
      p2_ans_q  <= '0;
      p1_vld_q  <= 1'b0;
      p2_vld_q  <= 1'b0;
      p1_lock_q <= 1'b0;
      p2_lock_q <= 1'b0;
      hp1_q     <= HP_RST;
      hp2_q     <= HP_RST;
      cnt_q     <= '0;
      JUDG_OUT  <= 2'b00;
      WRONG_OUT <= 1'b0;
      HP_OUT    <= 2'b00;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (STATE_IN == ST_INPUT) state_q <= S_OPEN;
        end
        S_OPEN, S_WPULSE: begin
          if (STATE_IN != ST_INPUT) begin
            p1_vld_q  <= 1'b0;
            p2_vld_q  <= 1'b0;
            WRONG_OUT <= 1'b0;
            cnt_q     <= '0;
            state_q   <= S_IDLE;
          end else begin
            if (p1_take) begin
              p1_ans_q <= P1_ANS;
              p1_vld_q <= 1'b1;
            end
            if (p2_take) begin
              p2_ans_q <= P2_ANS;
              p2_vld_q <= 1'b1;
            end
            // Answers captured during the pulse wait in OPEN and go to CHECK from there.
            if (state_q == S_OPEN) begin
              if (p1_take || p2_take || p1_vld_q || p2_vld_q) state_q <= S_CHECK;
            end else if (cnt_q == CNT_LAST) begin
              WRONG_OUT <= 1'b0;
              cnt_q     <= '0;
              state_q   <= S_OPEN;
            end else begin
              cnt_q <= cnt_q + 1'b1;
            end
          end
        end
        S_CHECK: begin
          p1_vld_q <= 1'b0;
          p2_vld_q <= 1'b0;
          if (p1_ok && p2_ok) begin
            JUDG_OUT <= 2'b11;
            state_q  <= S_DECIDED;
          end else if (p1_ok) begin
            JUDG_OUT <= 2'b01;
            hp2_q    <= hp2_d;
            if (hp2_d == 3'd0) HP_OUT <= 2'b01;
            state_q  <= S_DECIDED;
          end else if (p2_ok) begin
            JUDG_OUT <= 2'b10;
            hp1_q    <= hp1_d;
            if (hp1_d == 3'd0) HP_OUT <= 2'b10;
            state_q  <= S_DECIDED;
          end else if (p1_bad || p2_bad) begin
            p1_lock_q <= lock1_d;
            p2_lock_q <= lock2_d;
            if (lock1_d && lock2_d) begin
              JUDG_OUT <= 2'b11;
              state_q  <= S_DECIDED;
            end else begin
              WRONG_OUT <= 1'b1;
              cnt_q     <= '0;
              state_q   <= S_WPULSE;
            end
          end else begin
            state_q <= S_OPEN;
          end
        end
        S_DECIDED: begin
          if (STATE_IN == ST_READY) begin
            JUDG_OUT  <= 2'b00;
            p1_lock_q <= 1'b0;
            p2_lock_q <= 1'b0;
            state_q   <= (HP_OUT != 2'b00) ? S_OVER : S_IDLE;
          end
        end
        S_OVER: begin
          if (STATE_IN == ST_READY) JUDG_OUT <= 2'b00;
        end
        default: state_q <= S_IDLE;
      endcase
      // A new question always frees both players, overriding any lock set above.
      if (STATE_IN == ST_QUESTION) begin
        p1_lock_q <= 1'b0;
        p2_lock_q <= 1'b0;
      end
    end
  end

  assign DBG_STATE = state_q;
  assign DBG_HP1   = hp1_q;
  assign DBG_HP2   = hp2_q;

endmodule

// File: tb/tb_answer_arbiter.sv
// Directed bench for answer_arbiter: scoring, lockout, draws, game over, NEW_GAME and async reset.
module tb_answer_arbiter;

  localparam logic [3:0] ST_READY    = 4'b0010;
  localparam logic [3:0] ST_QUESTION = 4'b0011;
  localparam logic [3:0] ST_INPUT    = 4'b0100;

  logic       CLK, RST_N, NEW_GAME, P1_VALID, P2_VALID, WRONG_OUT;
  logic [3:0] STATE_IN;
  logic [7:0] KEY_A, KEY_B, P1_ANS, P2_ANS;
  logic [1:0] JUDG_OUT, HP_OUT;
  logic [2:0] DBG_STATE, DBG_HP1, DBG_HP2;

  int n_checks = 0;
  int n_err    = 0;

  answer_arbiter #(.ANS_W(8), .HP_INIT(3), .WRONG_HOLD(2)) dut (
    .CLK(CLK), .RST_N(RST_N), .STATE_IN(STATE_IN), .NEW_GAME(NEW_GAME),
    .KEY_A(KEY_A), .KEY_B(KEY_B), .P1_VALID(P1_VALID), .P2_VALID(P2_VALID),
    .P1_ANS(P1_ANS), .P2_ANS(P2_ANS), .JUDG_OUT(JUDG_OUT), .WRONG_OUT(WRONG_OUT),
    .HP_OUT(HP_OUT), .DBG_STATE(DBG_STATE), .DBG_HP1(DBG_HP1), .DBG_HP2(DBG_HP2)
  );

  // clock / reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  // driver tasks
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic answer(input logic v1, input logic [7:0] a1, input logic v2, input logic [7:0] a2);
    P1_VALID = v1; P1_ANS = a1;
    P2_VALID = v2; P2_ANS = a2;
    tick();
    P1_VALID = 1'b0;
    P2_VALID = 1'b0;
  endtask

  task automatic new_question();
    STATE_IN = ST_QUESTION;
    tick();
    STATE_IN = ST_INPUT;
    tick();
  endtask

  task automatic to_ready();
    STATE_IN = ST_READY;
    tick();
  endtask

  initial begin
    RST_N = 1'b0; NEW_GAME = 1'b0; STATE_IN = ST_READY;
    KEY_A = 8'd7; KEY_B = 8'd13;
    P1_VALID = 1'b0; P2_VALID = 1'b0; P1_ANS = 8'd0; P2_ANS = 8'd0;
    tick();
    tick();
    chk("rst_judg", {6'd0, JUDG_OUT}, 8'h00);
    chk("rst_wrong", {7'd0, WRONG_OUT}, 8'h00);
    chk("rst_hp_out", {6'd0, HP_OUT}, 8'h00);
    chk("rst_hp1", {5'd0, DBG_HP1}, 8'd3);
    chk("rst_hp2", {5'd0, DBG_HP2}, 8'd3);
    chk("rst_state", {5'd0, DBG_STATE}, 8'd0);
    RST_N = 1'b1;
    tick();

    // Round 1: VALID in the first INPUT cycle is ignored, then P1 answers 13.
    STATE_IN = ST_QUESTION;
    tick();
    STATE_IN = ST_INPUT;
    answer(1'b1, 8'd13, 1'b0, 8'd0);
    tick();
    chk("r1_first_cycle_ignored_state", {5'd0, DBG_STATE}, 8'd1);
    chk("r1_first_cycle_ignored_judg", {6'd0, JUDG_OUT}, 8'h00);
    answer(1'b1, 8'd13, 1'b0, 8'd0);
    chk("r1_latency_one_edge", {6'd0, JUDG_OUT}, 8'h00);
    tick();
    chk("r1_judg", {6'd0, JUDG_OUT}, 8'h01);
    chk("r1_hp2", {5'd0, DBG_HP2}, 8'd2);
    chk("r1_hp1", {5'd0, DBG_HP1}, 8'd3);
    chk("r1_hp_out", {6'd0, HP_OUT}, 8'h00);
    tick();
    chk("r1_judg_hold", {6'd0, JUDG_OUT}, 8'h01);
    to_ready();
    chk("r1_ready_clear", {6'd0, JUDG_OUT}, 8'h00);

    // Round 2: P2 wrong -> 2-cycle pulse, P2 locked, then P1 scores with 7.
    new_question();
    answer(1'b0, 8'd0, 1'b1, 8'd5);
    chk("r2_no_wrong_yet", {7'd0, WRONG_OUT}, 8'h00);
    tick();
    chk("r2_wrong_c1", {7'd0, WRONG_OUT}, 8'h01);
    chk("r2_judg_none", {6'd0, JUDG_OUT}, 8'h00);
    tick();
    chk("r2_wrong_c2", {7'd0, WRONG_OUT}, 8'h01);
    tick();
    chk("r2_wrong_end", {7'd0, WRONG_OUT}, 8'h00);
    answer(1'b0, 8'd0, 1'b1, 8'd7);
    tick();
    chk("r2_locked_state", {5'd0, DBG_STATE}, 8'd1);
    chk("r2_locked_judg", {6'd0, JUDG_OUT}, 8'h00);
    answer(1'b1, 8'd7, 1'b0, 8'd0);
    tick();
    chk("r2_judg", {6'd0, JUDG_OUT}, 8'h01);
    chk("r2_hp2", {5'd0, DBG_HP2}, 8'd1);
    to_ready();

    // Round 3: both correct on the same edge -> draw, HP unchanged.
    new_question();
    answer(1'b1, 8'd7, 1'b1, 8'd13);
    tick();
    chk("r3_judg_draw", {6'd0, JUDG_OUT}, 8'h03);
    chk("r3_hp1", {5'd0, DBG_HP1}, 8'd3);
    chk("r3_hp2", {5'd0, DBG_HP2}, 8'd1);
    chk("r3_wrong", {7'd0, WRONG_OUT}, 8'h00);
    to_ready();

    // Round 4: P1 wrong (pulse), then P2 wrong -> draw without a pulse.
    new_question();
    answer(1'b1, 8'd4, 1'b0, 8'd0);
    tick();
    chk("r4_wrong_c1", {7'd0, WRONG_OUT}, 8'h01);
    tick();
    chk("r4_wrong_c2", {7'd0, WRONG_OUT}, 8'h01);
    tick();
    chk("r4_wrong_end", {7'd0, WRONG_OUT}, 8'h00);
    answer(1'b0, 8'd0, 1'b1, 8'd9);
    tick();
    chk("r4_judg_draw", {6'd0, JUDG_OUT}, 8'h03);
    chk("r4_no_wrong", {7'd0, WRONG_OUT}, 8'h00);
    chk("r4_hp2", {5'd0, DBG_HP2}, 8'd1);
    to_ready();

    // Round 5: P1's third win drains P2 -> JUDG 01 and HP_OUT 01 together.
    new_question();
    answer(1'b1, 8'd13, 1'b0, 8'd0);
    tick();
    chk("r5_judg", {6'd0, JUDG_OUT}, 8'h01);
    chk("r5_hp_out_win", {6'd0, HP_OUT}, 8'h01);
    chk("r5_hp2_zero", {5'd0, DBG_HP2}, 8'd0);
    answer(1'b0, 8'd0, 1'b1, 8'd7);
    tick();
    chk("r5_decided_hold", {6'd0, JUDG_OUT}, 8'h01);
    to_ready();
    chk("r5_over_judg", {6'd0, JUDG_OUT}, 8'h00);
    chk("r5_over_state", {5'd0, DBG_STATE}, 8'd5);
    new_question();
    answer(1'b1, 8'd7, 1'b1, 8'd13);
    tick();
    tick();
    chk("r5_over_ignores", {6'd0, JUDG_OUT}, 8'h00);
    chk("r5_over_hp_held", {6'd0, HP_OUT}, 8'h01);
    NEW_GAME = 1'b1;
    tick();
    NEW_GAME = 1'b0;
    chk("ng_hp_out", {6'd0, HP_OUT}, 8'h00);
    chk("ng_hp1", {5'd0, DBG_HP1}, 8'd3);
    chk("ng_hp2", {5'd0, DBG_HP2}, 8'd3);
    chk("ng_state", {5'd0, DBG_STATE}, 8'd0);

    // Round 6: asynchronous reset while the wrong pulse is active.
    new_question();
    answer(1'b1, 8'd2, 1'b0, 8'd0);
    tick();
    chk("r6_wrong_before_rst", {7'd0, WRONG_OUT}, 8'h01);
    #2;
    RST_N = 1'b0;
    #1;
    chk("r6_async_wrong", {7'd0, WRONG_OUT}, 8'h00);
    chk("r6_async_judg", {6'd0, JUDG_OUT}, 8'h00);
    chk("r6_async_hp_out", {6'd0, HP_OUT}, 8'h00);
    chk("r6_async_state", {5'd0, DBG_STATE}, 8'd0);
    tick();
    RST_N = 1'b1;
    tick();
    chk("r6_after_rst_wrong", {7'd0, WRONG_OUT}, 8'h00);

    // final report
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/answer_arbiter.md
# answer_arbiter

Two-player answer arbiter and HP keeper for the factorization duel. It sits between the two player answer-entry units and the round controller. It accepts answers only while the controller reports the INPUT state, and grants the single judgement slot to the first correct answer. It locks out players who answer wrong and tracks both players' HP. It drives the controller's JUDG, WRONG and HP inputs.

## Interface
- ANS_W, 8: answer/key width in bits.
- HP_INIT, 3: starting HP per player. Legal range is 1..7.
- WRONG_HOLD, 2: number of cycles WRONG_OUT stays high per wrong answer. Minimum 1.
- CLK  in  1  system clock.
- RST_N  in  1  reset, asynchronous, active-low.
- STATE_IN  in  4  controller state: 4'b0010 = READY, 4'b0011 = QUESTION, 4'b0100 = INPUT.
- NEW_GAME  in  1  one-cycle pulse that restores HP and clears all round state.
- KEY_A, KEY_B  in  ANS_W each  the two correct factors of the current question. Stable while STATE_IN = INPUT.
- P1_VALID, P2_VALID  in  1 each  one-cycle answer-submit pulses.
- P1_ANS, P2_ANS  in  ANS_W each  answer values, sampled when the matching VALID is high.
- JUDG_OUT  out  2  00 = none, 01 = P1 scored, 10 = P2 scored, 11 = draw.
- WRONG_OUT  out  1  wrong-answer indication.
- HP_OUT  out  2  00 = game running, 01 = P2 HP is 0 (win), 10 = P1 HP is 0 (lose).

## Operation
- FSM states: IDLE, OPEN, CHECK, WPULSE, DECIDED, OVER.
- IDLE: waits for STATE_IN = INPUT, then goes to OPEN.
- OPEN: a VALID pulse from an unlocked player captures that player's answer and a valid flag. The FSM then goes to CHECK.
  - Both players may be captured in the same cycle.
  - VALID from a locked player is ignored.
- CHECK: lasts one cycle. An answer is correct iff it equals KEY_A or KEY_B. VALID pulses arriving during CHECK are dropped. Resolution:
  - Only P1 correct, or P1 correct while P2 is wrong: JUDG_OUT = 01, P2 HP decrements. Go to DECIDED.
  - Only P2 correct: JUDG_OUT = 10, P1 HP decrements. Go to DECIDED.
  - Both correct in the same cycle: JUDG_OUT = 11, no HP change. Go to DECIDED.
  - Wrong answer(s), and after locking them both players are locked: JUDG_OUT = 11, no WRONG_OUT. Go to DECIDED.
  - One wrong answer and the other player still unlocked: lock the wrong player, WRONG_OUT = 1. Go to WPULSE.
- WPULSE: counts WRONG_HOLD cycles including the first one. At the end it drops WRONG_OUT and returns to OPEN. The other player may answer during WPULSE; those answers are captured and resolved after the pulse ends.
- DECIDED: holds JUDG_OUT until STATE_IN = READY. Then it clears JUDG_OUT and both lockouts and goes to IDLE. If HP_OUT ≠ 00, it goes to OVER instead.
- OVER: JUDG_OUT clears at READY. HP_OUT is held. No answers are accepted until NEW_GAME.
- HP:
  - 3-bit counters, each loaded with HP_INIT.
  - Decrement saturates at 0.
  - HP_OUT updates on the same edge as the decrement: 01 when P2 HP reaches 0, 10 when P1 HP reaches 0.
- Lockouts also clear whenever STATE_IN = QUESTION, which marks a new question.
- Priority: RST_N > NEW_GAME > everything else. NEW_GAME in any state behaves like reset.
- STATE_IN leaving INPUT while in OPEN or WPULSE: clear any captured answer, clear WRONG_OUT, go to IDLE.

## Timing
- Reset values: JUDG_OUT = 00, WRONG_OUT = 0, HP_OUT = 00, both HP = HP_INIT, FSM = IDLE, no lockouts.
- All outputs are registered.
- Answer on clock edge k → JUDG_OUT / WRONG_OUT / HP_OUT valid after edge k+1 (2-edge latency).
- WRONG_OUT high for exactly WRONG_HOLD cycles.
- IDLE → OPEN takes one cycle after STATE_IN = INPUT is first sampled. VALID pulses in that first cycle are ignored.
- An asynchronous reset mid-round forces reset values immediately.

## Test plan
- HP_INIT = 3, KEYs = 7 and 13, INPUT state, P1 answers 13 → JUDG_OUT = 01 two edges later, P2 HP = 2, HP_OUT = 00. STATE_IN = READY → JUDG_OUT = 00.
- P2 answers 5 → WRONG_OUT high for 2 cycles, then P2 VALID is ignored. P1 answers 7 → JUDG_OUT = 01.
- P1 answers 7 and P2 answers 13 on the same edge → JUDG_OUT = 11, both HP unchanged.
- P1 wrong, then P2 wrong → first answer gives a WRONG pulse, second gives JUDG_OUT = 11 with no WRONG pulse.
- P1 scores three rounds → third round gives JUDG_OUT = 01 and HP_OUT = 01 on the same edge. Further VALIDs are ignored. NEW_GAME → HP_OUT = 00, HP = 3/3.
- RST_N low during WPULSE → WRONG_OUT = 0 immediately, all outputs at reset values.
